// File: rtl/robot_diagnostics.sv
// UART diagnostic block: 8N1 receiver and CTS-gated transmitter running side by side,
// with a switch-selected LED view of the last received / transmitted byte.
module robot_diagnostics #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sample_clock,
  input  logic       key,
  input  logic [9:0] sw,
  input  logic       uart_rx,
  input  logic       uart_cts,
  output logic       uart_tx,
  output logic       uart_rts,
  output logic       gpio_rx,
  output logic       gpio_cts,
  output logic [9:0] led
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT_CTS, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [1:0] rx_sync_q, cts_sync_q, sw_meta_q, sw_sync_q;
  logic       rx_prev_q, sw8_prev_q;
  logic       rx_s, cts_s, rx_fall, tx_req;

  rx_state_t  rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic       ferr_q, ferr_d;

  tx_state_t  tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_q, tx_d;
  logic       rts_q;
  logic [9:0] led_q, led_d;

  assign rx_s    = rx_sync_q[1];
  assign cts_s   = cts_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign tx_req  = sw_sync_q[0] & ~sw8_prev_q;

  // Two-flop synchronizers; sw_*_q[0] carries sw[8], [1] carries sw[9].
  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      rx_sync_q  <= 2'b11;
      cts_sync_q <= 2'b11;
      sw_meta_q  <= 2'b00;
      sw_sync_q  <= 2'b00;
      rx_prev_q  <= 1'b1;
      sw8_prev_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx};
      cts_sync_q <= {cts_sync_q[0], uart_cts};
      sw_meta_q  <= sw[9:8];
      sw_sync_q  <= sw_meta_q;
      rx_prev_q  <= rx_s;
      sw8_prev_q <= sw_sync_q[0];
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    ferr_d     = ferr_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        // A line back high at mid-start was only a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d = RX_IDLE;
        if (rx_s) begin
          rx_byte_d = rx_shift_q;
          ferr_d    = 1'b0;
        end else begin
          ferr_d    = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_req) begin
          tx_byte_d  = sw[7:0];
          tx_state_d = TX_WAIT_CTS;
        end
      end
      TX_WAIT_CTS: begin
        tx_cnt_d = '0;
        if (!cts_s) tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so it lines up with the state register.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_byte_q[tx_bit_d];
      default:  tx_d = 1'b1;
    endcase
    led_d = {ferr_q, tx_state_q != TX_IDLE, sw_sync_q[1] ? tx_byte_q : rx_byte_q};
  end

  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
      rts_q      <= 1'b1;
      led_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
      rts_q      <= 1'b0;
      led_q      <= led_d;
    end
  end

  assign uart_tx  = tx_q;
  assign uart_rts = rts_q;
  assign gpio_rx  = rx_s;
  assign gpio_cts = cts_s;
  assign led      = led_q;

endmodule

// File: tb/tb_robot_diagnostics.sv
// Directed bench for robot_diagnostics at 50 MHz, 115200 baud.
module tb_robot_diagnostics;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       key = 1'b1;
  logic [9:0] sw = '0;
  logic       uart_rx = 1'b1;
  logic       uart_cts = 1'b1;
  logic       uart_tx, uart_rts, gpio_rx, gpio_cts;
  logic [9:0] led;

  int checks = 0;
  int errors = 0;

  robot_diagnostics #(.CLKS_PER_BIT(CPB)) dut (
    .sample_clock(clk), .key(key), .sw(sw), .uart_rx(uart_rx), .uart_cts(uart_cts),
    .uart_tx(uart_tx), .uart_rts(uart_rts), .gpio_rx(gpio_rx), .gpio_cts(gpio_cts),
    .led(led)
  );

  always #10 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    sw[8] = 1'b1;
    wait_clks(5);
    sw[8] = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop_bit;
    wait_clks(CPB);
    uart_rx = 1'b1;
  endtask

  // Waits for the start bit, then samples every bit at its centre.
  task automatic check_tx_frame(input logic [7:0] b, input string name);
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start_timeout: uart_tx=%b required 0", name, uart_tx);
      return;
    end
    wait_clks(CPB / 2);
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start_bit: got %b required 0", name, uart_tx);
    end
    for (int i = 0; i < 8; i++) begin
      wait_clks(CPB);
      checks++;
      if (uart_tx !== b[i]) begin
        errors++;
        $display("FAIL %s data_bit%0d: got %b required %b", name, i, uart_tx, b[i]);
      end
    end
    wait_clks(CPB);
    checks++;
    if (uart_tx !== 1'b1 || led[8] !== 1'b1) begin
      errors++;
      $display("FAIL %s stop_bit: tx=%b busy=%b required tx=1 busy=1", name, uart_tx, led[8]);
    end
    wait_clks(CPB / 2 + 4);
    checks++;
    if (led[8] !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s after_frame: busy=%b tx=%b required busy=0 tx=1", name, led[8], uart_tx);
    end
  endtask

  task automatic check_rx_led(input logic [7:0] b, input logic fe, input string name);
    checks++;
    if (led[7:0] !== b || led[9] !== fe) begin
      errors++;
      $display("FAIL %s: led[7:0]=%h led[9]=%b required %h %b", name, led[7:0], led[9], b, fe);
    end
  endtask

  task automatic test_reset();
    #5 key = 1'b0;
    wait_clks(4);
    checks++;
    if (uart_tx !== 1'b1 || uart_rts !== 1'b1 || led !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold: tx=%b rts=%b led=%h required 1 1 000", uart_tx, uart_rts, led);
    end
    key = 1'b1;
    wait_clks(3);
    checks++;
    if (uart_tx !== 1'b1 || uart_rts !== 1'b0 || led !== 10'd0 || gpio_rx !== 1'b1 || gpio_cts !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: tx=%b rts=%b led=%h rx=%b cts=%b required 1 0 000 1 1",
               uart_tx, uart_rts, led, gpio_rx, gpio_cts);
    end
  endtask

  task automatic test_rx();
    sw[9] = 1'b0;
    send_rx(8'hAA, 1'b1);
    wait_clks(3);
    check_rx_led(8'hAA, 1'b0, "rx_aa");
    send_rx(8'h55, 1'b1);
    wait_clks(3);
    check_rx_led(8'h55, 1'b0, "rx_55");
  endtask

  task automatic test_tx_ff();
    uart_cts = 1'b0;
    sw[7:0]  = 8'hFF;
    wait_clks(4);
    fork
      pulse_req();
      check_tx_frame(8'hFF, "tx_ff");
    join
    sw[9] = 1'b1;
    wait_clks(4);
    checks++;
    if (led[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL tx_ff_led: led[7:0]=%h required ff", led[7:0]);
    end
    sw[9] = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_back_to_back();
    send_rx(8'h81, 1'b1);
    wait_clks(3);
    check_rx_led(8'h81, 1'b0, "rx_81");
    sw[7:0] = 8'h55;
    fork
      pulse_req();
      check_tx_frame(8'h55, "b2b_tx");
      begin
        send_rx(8'h55, 1'b1);
        send_rx(8'h55, 1'b1);
      end
    join
    wait_clks(3);
    check_rx_led(8'h55, 1'b0, "b2b_rx");
  endtask

  task automatic test_cts_flow();
    logic bad;
    uart_cts = 1'b1;
    sw[7:0]  = 8'h3C;
    wait_clks(4);
    pulse_req();
    bad = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || led[8] !== 1'b1) begin
      errors++;
      $display("FAIL wait_cts: tx_went_low=%b busy=%b required 0 1", bad, led[8]);
    end
    fork
      begin
        uart_cts = 1'b0;
        check_tx_frame(8'h3C, "cts_tx");
      end
      begin
        wait_clks(3 * CPB);
        sw[7:0] = 8'hC3;
        pulse_req();
      end
    join
    bad = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad = 1'b1;
    end
    sw[9] = 1'b1;
    wait_clks(4);
    checks++;
    if (bad || led[8] !== 1'b0 || led[7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL ignored_req: extra_frame=%b busy=%b tx_byte=%h required 0 0 3c", bad, led[8], led[7:0]);
    end
    sw[9] = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_framing_glitch();
    send_rx(8'h12, 1'b0);
    wait_clks(3);
    check_rx_led(8'h55, 1'b1, "frame_err");
    wait_clks(CPB);
    send_rx(8'h34, 1'b1);
    wait_clks(3);
    check_rx_led(8'h34, 1'b0, "frame_clear");
    uart_rx = 1'b0;
    wait_clks(2);
    uart_rx = 1'b1;
    wait_clks(CPB);
    check_rx_led(8'h34, 1'b0, "glitch");
    send_rx(8'h96, 1'b1);
    wait_clks(3);
    check_rx_led(8'h96, 1'b0, "after_glitch");
  endtask

  task automatic test_reset_midframe();
    sw[7:0] = 8'h00;
    pulse_req();
    wait_clks(CPB);
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL midframe_low: tx=%b required 0", uart_tx);
    end
    #3 key = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || uart_rts !== 1'b1 || led !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: tx=%b rts=%b led=%h required 1 1 000", uart_tx, uart_rts, led);
    end
    @(negedge clk);
    key = 1'b1;
    wait_clks(3);
    checks++;
    if (uart_tx !== 1'b1 || uart_rts !== 1'b0 || led[8] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: tx=%b rts=%b busy=%b required 1 0 0", uart_tx, uart_rts, led[8]);
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx_ff();
    test_back_to_back();
    test_cts_flow();
    test_framing_glitch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/robot_diagnostics.md
ROBOT_DIAGNOSTICS -- requirements
Module: robot_diagnostics

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (115200 baud at 50 MHz, 8680 ns per bit).
REQ-002 The block SHALL have port sample_clock, input, 1 bit: the single system clock, 50 MHz, all logic on its rising edge.
REQ-003 The block SHALL have port key, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port sw, input, 10 bits: sw[7:0] is the TX data byte, sw[8] is the transmit request, sw[9] is the LED display select.
REQ-005 The block SHALL have port uart_rx, input, 1 bit: UART serial receive line, idle high.
REQ-006 The block SHALL have port uart_cts, input, 1 bit: clear-to-send, active-low, from the host.
REQ-007 The block SHALL have port uart_tx, output, 1 bit: UART serial transmit line, idle high.
REQ-008 The block SHALL have port uart_rts, output, 1 bit: ready-to-send, active-low, to the host.
REQ-009 The block SHALL have port gpio_rx, output, 1 bit: probe copy of the synchronized uart_rx.
REQ-010 The block SHALL have port gpio_cts, output, 1 bit: probe copy of the synchronized uart_cts.
REQ-011 The block SHALL have port led, output, 10 bits: diagnostic display.

Function
REQ-012 The block SHALL pass each of uart_rx, uart_cts and sw[9:8] through a 2-flop synchronizer before use.
REQ-013 The UART format SHALL be 8N1: start bit 0, 8 data bits LSB first, no parity, one stop bit 1.
REQ-014 The RX state machine SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge of rx.
- START: sample at CLKS_PER_BIT/2 (217). If rx = 0, go to DATA; if rx = 1, treat as a glitch and return to IDLE.
- DATA: sample every CLKS_PER_BIT at mid-bit, 8 samples, shifting LSB first.
- STOP: sample at mid-bit. If rx = 1, latch rx_byte and clear the framing-error flag. If rx = 0, keep the old rx_byte and set the framing-error flag. Return to IDLE.
REQ-015 rx_byte SHALL update exactly once per good frame, within one stop-bit time after the start edge plus 10 bit times.
REQ-016 uart_rts SHALL be 0 whenever the RX state machine is out of reset, because received bytes are latched immediately and never back-pressure.
REQ-017 A transmit request SHALL be a synchronized rising edge of sw[8]; pulses of 100 ns (5 clocks) or longer SHALL be detected.
REQ-018 On a request the TX path SHALL capture sw[7:0] into tx_byte on the same clock edge.
REQ-019 The TX state machine SHALL have states IDLE, WAIT_CTS, START, DATA, STOP, each bit held CLKS_PER_BIT clocks.
- IDLE -> WAIT_CTS on a request.
- WAIT_CTS -> START when synchronized cts = 0.
- CTS is checked only before the start bit. A frame in progress completes regardless of cts.
REQ-020 Requests arriving while TX is not IDLE SHALL be ignored and SHALL not be queued.
REQ-021 uart_tx SHALL be 1 in IDLE, WAIT_CTS and STOP; 0 in START; tx_byte[i] during data bit i.
REQ-022 RX and TX SHALL operate fully independently and concurrently.
REQ-023 led[7:0] SHALL show rx_byte when sw[9] = 0 and tx_byte when sw[9] = 1.
REQ-024 led[8] SHALL be 1 while TX is not IDLE (busy).
REQ-025 led[9] SHALL be the sticky framing-error flag.

Reset
REQ-026 While key = 0 the block SHALL hold the following values, all registered:
- uart_tx = 1, uart_rts = 1
- led = 0, rx_byte = 0, tx_byte = 0
- both state machines in IDLE, counters and the framing flag cleared
- synchronizers preset to rx = 1, cts = 1, sw = 0
REQ-027 Reset asserted mid-frame SHALL abort RX and TX immediately; uart_tx SHALL return to 1 asynchronously.
REQ-028 After key rises the block SHALL begin operating within 3 clocks, and uart_rts SHALL go to 0 within that time.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset key = 0 then key = 1, with uart_rx = 1 -> uart_tx = 1, led = 0, uart_rts = 1 during reset and 0 after.
- Receive 0xAA at 8680 ns per bit with sw[9] = 0 -> led[7:0] = 0xAA after the stop bit; then receive 0x55 -> led[7:0] = 0x55; led[9] = 0.
- uart_cts = 0, sw[7:0] = 0xFF, 100 ns pulse on sw[8] -> uart_tx gives start 0, eight 1s, stop 1, 8680 ns each; led[8] high for 10 bit times; with sw[9] = 1, led[7:0] = 0xFF.
- sw[7:0] = 0x55 sent while two 0x55 bytes are received back-to-back -> TX waveform correct and led[7:0] = 0x55 with sw[9] = 0, showing the paths are independent.
- uart_cts = 1 then request 0x3C -> uart_tx stays 1 in WAIT_CTS; drop cts to 0 -> frame 0x3C sent; a second sw[8] pulse during the frame is ignored.
- Frame with stop bit 0 -> led[9] = 1 and led[7:0] unchanged; next good frame clears led[9]; a 2-clock low glitch on uart_rx gives no byte.
